// File: rtl/truth_table_sweeper.sv
// Walks a combinational DUT through all 2^N_IN input vectors, captures its truth table
// and compares it with a latched expected table. Define SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [(2**N_IN)-1:0]    expected,
    output logic [N_IN-1:0]         dut_in,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [N_IN:0]           fail_count,
    output logic [N_IN-1:0]         first_fail_idx,
    output logic [(2**N_IN)-1:0]    captured
);

    localparam int TW = 2**N_IN;
    localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
    localparam logic [N_IN-1:0] IDX_LAST   = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        FINISH
    } state_t;

    state_t              state, state_n;
    logic [N_IN-1:0]     idx, idx_n;
    logic [3:0]          cnt, cnt_n;
    logic [TW-1:0]       expected_q, expected_q_n;
    logic [TW-1:0]       captured_n;
    logic [N_IN:0]       fail_count_n;
    logic [N_IN-1:0]     first_fail_idx_n;
    logic                busy_n, done_n, pass_n;
    logic                mismatch, last;

    assign dut_in = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            expected_q     <= '0;
            captured       <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            cnt            <= cnt_n;
            expected_q     <= expected_q_n;
            captured       <= captured_n;
            fail_count     <= fail_count_n;
            first_fail_idx <= first_fail_idx_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
        end
    end

    always_comb begin
        state_n          = state;
        idx_n            = idx;
        cnt_n            = cnt;
        expected_q_n     = expected_q;
        captured_n       = captured;
        fail_count_n     = fail_count;
        first_fail_idx_n = first_fail_idx;
        busy_n           = busy;
        done_n           = 1'b0;
        pass_n           = pass;
        mismatch         = 1'b0;
        last             = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    expected_q_n     = expected;
                    captured_n       = '0;
                    fail_count_n     = '0;
                    first_fail_idx_n = '0;
                    pass_n           = 1'b0;
                    idx_n            = '0;
                    busy_n           = 1'b1;
                    cnt_n            = SETTLE_CNT;
                    state_n          = (SETTLE == 0) ? SAMPLE : WAIT;
                end
            end

            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_n = SAMPLE;
                end
            end

            SAMPLE: begin
                captured_n[idx] = dut_out;
                mismatch        = (dut_out != expected_q[idx]);
                if (mismatch) begin
                    fail_count_n = fail_count + 1'b1;
                    if (fail_count == '0) begin
                        first_fail_idx_n = idx;
                    end
                end
                last = (idx == IDX_LAST);
`ifdef SWEEP_STOP_ON_FAIL_EN
                last = last || mismatch;
`endif
                // done/pass are registered on entry to FINISH so they are visible during it
                if (last) begin
                    state_n = FINISH;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (fail_count_n == '0);
                end else begin
                    idx_n   = idx + 1'b1;
                    cnt_n   = SETTLE_CNT;
                    state_n = (SETTLE == 0) ? SAMPLE : WAIT;
                end
            end

            FINISH: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: 3-input majority (SETTLE=1) and A&B | C&~D (SETTLE=0) swept by two sweeper instances.
module tb_truth_table_sweeper;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        start3 = 1'b0;
    logic [7:0]  exp3   = '0;
    logic [2:0]  in3;
    logic        out3, busy3, done3, pass3;
    logic [3:0]  fc3;
    logic [2:0]  ffi3;
    logic [7:0]  cap3;

    logic        start4 = 1'b0;
    logic [15:0] exp4   = '0;
    logic [3:0]  in4;
    logic        out4, busy4, done4, pass4;
    logic [4:0]  fc4;
    logic [3:0]  ffi4;
    logic [15:0] cap4;

    assign out3 = (in3[2] & in3[1]) | (in3[2] & in3[0]) | (in3[1] & in3[0]);
    assign out4 = (in4[3] & in4[2]) | (in4[1] & ~in4[0]);

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3),
        .dut_in(in3), .dut_out(out3), .busy(busy3), .done(done3), .pass(pass3),
        .fail_count(fc3), .first_fail_idx(ffi3), .captured(cap3)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .expected(exp4),
        .dut_in(in4), .dut_out(out4), .busy(busy4), .done(done4), .pass(pass4),
        .fail_count(fc4), .first_fail_idx(ffi4), .captured(cap4)
    );

    // Cycle numbering: the cycle in which start is high is cycle 0.
    task automatic sweep3(input logic [7:0] e, input bit poke, input int nvec,
                          output int lat, output int seq_err);
        @(negedge clk);
        exp3 = e; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0; lat = 1; seq_err = 0;
        if (in3 !== 3'd0) seq_err++;
        while (done3 !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 7) begin
                start3 = 1'b1; exp3 = ~e;
            end else begin
                start3 = 1'b0;
            end
            if (lat <= 2 * nvec && in3 !== 3'((lat - 1) / 2)) seq_err++;
        end
        start3 = 1'b0;
    endtask

    task automatic sweep4(input logic [15:0] e, output int lat, output int busy_cyc);
        @(negedge clk);
        exp4 = e; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; lat = 1; busy_cyc = 0;
        if (busy4 === 1'b1) busy_cyc++;
        while (done4 !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy4 === 1'b1) busy_cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({in3, busy3, done3, pass3, fc3, ffi3, cap3} !== '0) begin
            bad++; $display("FAIL reset_u3 got=%h want=0", {in3, busy3, done3, pass3, fc3, ffi3, cap3});
        end
        total++;
        if ({in4, busy4, done4, pass4, fc4, ffi4, cap4} !== '0) begin
            bad++; $display("FAIL reset_u4 got=%h want=0", {in4, busy4, done4, pass4, fc4, ffi4, cap4});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_majority_pass;
        int lat, seq_err;
        sweep3(8'hE8, 1'b0, 8, lat, seq_err);
        total++; if (lat !== 17)      begin bad++; $display("FAIL maj_latency got=%0d want=17", lat); end
        total++; if (seq_err !== 0)   begin bad++; $display("FAIL maj_dut_in_seq errors=%0d want=0", seq_err); end
        total++; if (cap3 !== 8'hE8)  begin bad++; $display("FAIL maj_captured got=%h want=e8", cap3); end
        total++; if (pass3 !== 1'b1)  begin bad++; $display("FAIL maj_pass got=%b want=1", pass3); end
        total++; if (fc3 !== 4'd0)    begin bad++; $display("FAIL maj_fail_count got=%0d want=0", fc3); end
        total++; if (ffi3 !== 3'd0)   begin bad++; $display("FAIL maj_first_fail got=%0d want=0", ffi3); end
        @(negedge clk);
        total++; if (done3 !== 1'b0)  begin bad++; $display("FAIL maj_done_pulse got=%b want=0", done3); end
        total++; if (in3 !== 3'd7)    begin bad++; $display("FAIL maj_dut_in_hold got=%0d want=7", in3); end
        total++; if (pass3 !== 1'b1 || cap3 !== 8'hE8) begin
            bad++; $display("FAIL maj_results_hold pass=%b cap=%h want 1/e8", pass3, cap3);
        end
    endtask

`ifndef SWEEP_STOP_ON_FAIL_EN
    task automatic test_majority_mismatch;
        int lat, seq_err;
        sweep3(8'hE9, 1'b0, 8, lat, seq_err);
        total++; if (cap3 !== 8'hE8) begin bad++; $display("FAIL mm1_captured got=%h want=e8", cap3); end
        total++; if (pass3 !== 1'b0) begin bad++; $display("FAIL mm1_pass got=%b want=0", pass3); end
        total++; if (fc3 !== 4'd1)   begin bad++; $display("FAIL mm1_fail_count got=%0d want=1", fc3); end
        total++; if (ffi3 !== 3'd0)  begin bad++; $display("FAIL mm1_first_fail got=%0d want=0", ffi3); end
        sweep3(8'h17, 1'b0, 8, lat, seq_err);
        total++; if (fc3 !== 4'd8)   begin bad++; $display("FAIL mm8_fail_count got=%0d want=8", fc3); end
        total++; if (ffi3 !== 3'd0)  begin bad++; $display("FAIL mm8_first_fail got=%0d want=0", ffi3); end
        total++; if (pass3 !== 1'b0) begin bad++; $display("FAIL mm8_pass got=%b want=0", pass3); end
    endtask
`endif

    task automatic test_and_or;
        int lat, busy_cyc;
        sweep4(16'hF444, lat, busy_cyc);
        total++; if (lat !== 17)       begin bad++; $display("FAIL ao_latency got=%0d want=17", lat); end
        total++; if (busy_cyc !== 16)  begin bad++; $display("FAIL ao_busy_cycles got=%0d want=16", busy_cyc); end
        total++; if (cap4 !== 16'hF444) begin bad++; $display("FAIL ao_captured got=%h want=f444", cap4); end
        total++; if (pass4 !== 1'b1)   begin bad++; $display("FAIL ao_pass got=%b want=1", pass4); end
`ifndef SWEEP_STOP_ON_FAIL_EN
        // F4F4 differs from the true table at vectors 4, 5 and 7
        sweep4(16'hF4F4, lat, busy_cyc);
        total++; if (fc4 !== 5'd3)     begin bad++; $display("FAIL ao_mm_fail_count got=%0d want=3", fc4); end
        total++; if (ffi4 !== 4'd4)    begin bad++; $display("FAIL ao_mm_first_fail got=%0d want=4", ffi4); end
        total++; if (pass4 !== 1'b0)   begin bad++; $display("FAIL ao_mm_pass got=%b want=0", pass4); end
`endif
    endtask

    task automatic test_busy_ignore;
        int lat, seq_err;
        sweep3(8'hE8, 1'b1, 8, lat, seq_err);
        total++; if (lat !== 17)      begin bad++; $display("FAIL bi_latency got=%0d want=17", lat); end
        total++; if (seq_err !== 0)   begin bad++; $display("FAIL bi_dut_in_seq errors=%0d want=0", seq_err); end
        total++; if (cap3 !== 8'hE8 || pass3 !== 1'b1 || fc3 !== 4'd0 || ffi3 !== 3'd0) begin
            bad++; $display("FAIL bi_results cap=%h pass=%b fc=%0d ffi=%0d want e8/1/0/0", cap3, pass3, fc3, ffi3);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int n, done_seen, busy_seen, lat, seq_err;
        @(negedge clk);
        exp3 = 8'hE8; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0; n = 0;
        while (in3 !== 3'd5 && n < 50) begin @(negedge clk); n++; end
        total++; if (in3 !== 3'd5) begin bad++; $display("FAIL rst_reach_vec5 got=%0d want=5", in3); end
        #2 rst_n = 1'b0; start3 = 1'b1;
        #1;
        total++;
        if ({in3, busy3, done3, pass3, fc3, ffi3, cap3} !== '0) begin
            bad++; $display("FAIL rst_async_clear got=%h want=0", {in3, busy3, done3, pass3, fc3, ffi3, cap3});
        end
        @(negedge clk);
        rst_n = 1'b1; start3 = 1'b0;
        done_seen = 0; busy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done3 === 1'b1) done_seen++;
            if (busy3 === 1'b1) busy_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", done_seen); end
        total++; if (busy_seen !== 0) begin bad++; $display("FAIL rst_start_ignored got=%0d want=0", busy_seen); end
        sweep3(8'hE8, 1'b0, 8, lat, seq_err);
        total++; if (lat !== 17 || seq_err !== 0 || cap3 !== 8'hE8 || pass3 !== 1'b1) begin
            bad++; $display("FAIL rst_resweep lat=%0d seq=%0d cap=%h pass=%b want 17/0/e8/1", lat, seq_err, cap3, pass3);
        end
    endtask

`ifdef SWEEP_STOP_ON_FAIL_EN
    task automatic test_stop_on_fail;
        int lat, seq_err;
        // F8 first disagrees with the majority table at vector 4
        sweep3(8'hF8, 1'b0, 5, lat, seq_err);
        total++; if (lat !== 11)      begin bad++; $display("FAIL sof_latency got=%0d want=11", lat); end
        total++; if (fc3 !== 4'd1)    begin bad++; $display("FAIL sof_fail_count got=%0d want=1", fc3); end
        total++; if (ffi3 !== 3'd4)   begin bad++; $display("FAIL sof_first_fail got=%0d want=4", ffi3); end
        total++; if (cap3 !== 8'h08)  begin bad++; $display("FAIL sof_captured got=%h want=08", cap3); end
        total++; if (pass3 !== 1'b0)  begin bad++; $display("FAIL sof_pass got=%b want=0", pass3); end
    endtask
`endif

    initial begin
        test_reset;
        test_majority_pass;
`ifndef SWEEP_STOP_ON_FAIL_EN
        test_majority_mismatch;
`endif
        test_and_or;
        test_busy_ignore;
        test_reset_mid_sweep;
`ifdef SWEEP_STOP_ON_FAIL_EN
        test_stop_on_fail;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
